// File: rtl/fm_wb_pkg.sv
// Shared definitions for the FM sweep Wishbone master: register map,
// controller state encoding and power-on defaults of the latched settings.
package fm_wb_pkg;

    localparam logic [1:0] CARRIER_CENTER_FREQUENCY = 2'd0;
    localparam logic [1:0] MODULATION_FREQUENCY     = 2'd1;
    localparam logic [1:0] MODULATION_DEVIATION     = 2'd2;

    localparam logic [31:0] DEFAULT_CARRIER  = 32'h0044_4444;
    localparam logic [31:0] DEFAULT_MOD_FREQ = 32'h0000_01bf;
    localparam logic [31:0] DEFAULT_MOD_DEV  = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        WR_MF,
        WR_DEV,
        WR_CF,
        WAIT_ACK,
        DWELL,
        FINISH
    } state_t;

endpackage

// File: rtl/wb_single_write.sv
// Single outstanding Wishbone write: strobe/stall/ack handshake plus the
// timeout watchdog that covers both the stall-hold and the ack wait.
module wb_single_write #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,       // controller is in an issue state
    input  logic          pending,   // controller is waiting for the ack
    input  logic [1:0]    addr,
    input  logic [DW-1:0] data,
    input  logic          wb_stall,
    input  logic          wb_ack,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [1:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          busy,
    output logic          accept,    // strobe taken by the slave this cycle
    output logic          ok,        // ack received this cycle
    output logic          timeout    // watchdog expired this cycle
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;

    // An ack while still strobing is a protocol violation; only pending looks at ack.
    assign waiting = (req && wb_stall) || (pending && !wb_ack);
    assign timeout = waiting && (wait_cnt == CW'(TIMEOUT - 1));
    assign accept  = req && !wb_stall;
    assign ok      = pending && wb_ack;

    assign wb_cyc  = req || pending;
    assign wb_stb  = req;
    assign wb_we   = req;
    assign wb_addr = req ? addr : 2'd0;
    assign wb_data = req ? data : '0;
    assign busy    = wb_cyc;

    // Count consecutive stalled/unacknowledged cycles; any progress restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)                  wait_cnt <= '0;
        else if (waiting && !timeout) wait_cnt <= wait_cnt + CW'(1);
        else                         wait_cnt <= '0;
    end

endmodule

// File: rtl/fm_sweep_wb_master.sv
// Programs the FM generator over Wishbone: modulation frequency, deviation,
// then a carrier sweep from start to stop with a dwell between points.
module fm_sweep_wb_master
    import fm_wb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DWELL_W = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [DW-1:0]      i_start_freq,
    input  logic [DW-1:0]      i_stop_freq,
    input  logic [DW-1:0]      i_step,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [DW-1:0]      i_mod_freq,
    input  logic [DW-1:0]      i_mod_dev,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic               o_wb_we,
    output logic [1:0]         o_wb_addr,
    output logic [DW-1:0]      o_wb_data,
    input  logic               i_wb_ack,
    input  logic               i_wb_stall,
    input  logic [DW-1:0]      i_wb_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [DW-1:0]      o_cur_freq
);

    state_t             state, state_nxt;
    logic [DW-1:0]      start_r, stop_r, step_r, mod_freq_r, mod_dev_r, point;
    logic [DWELL_W-1:0] dwell_r, dwell_cnt;
    logic [1:0]         wr_addr, addr_mux;
    logic [DW-1:0]      data_mux, next_point;
    logic [DW:0]        sum;
    logic               last_point, req, pending, accept, ok, timeout;
    logic               err_r, wr_busy;
    logic [DW-1:0]      cur_freq_r;
    logic               unused_ok;

    // Sweep arithmetic in DW+1 bits so cur+step never wraps; stop is always the final point.
    assign sum        = {1'b0, point} + {1'b0, step_r};
    assign next_point = (sum > {1'b0, stop_r}) ? stop_r : sum[DW-1:0];
    assign last_point = (point == stop_r) || (step_r == '0) || (start_r > stop_r);

    wb_single_write #(.DW(DW), .TIMEOUT(TIMEOUT)) u_write (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .req      (req),
        .pending  (pending),
        .addr     (addr_mux),
        .data     (data_mux),
        .wb_stall (i_wb_stall),
        .wb_ack   (i_wb_ack),
        .wb_cyc   (o_wb_cyc),
        .wb_stb   (o_wb_stb),
        .wb_we    (o_wb_we),
        .wb_addr  (o_wb_addr),
        .wb_data  (o_wb_data),
        .busy     (wr_busy),
        .accept   (accept),
        .ok       (ok),
        .timeout  (timeout)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic and per-state bus request; abort only acts where no write is in flight.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_nxt = state;
        req       = 1'b0;
        pending   = 1'b0;
        addr_mux  = 2'd0;
        data_mux  = '0;
        case (state)
            IDLE: if (i_start) state_nxt = WR_MF;
            WR_MF, WR_DEV, WR_CF: begin
                req = 1'b1;
                case (state)
                    WR_MF:   begin addr_mux = MODULATION_FREQUENCY;     data_mux = mod_freq_r; end
                    WR_DEV:  begin addr_mux = MODULATION_DEVIATION;     data_mux = mod_dev_r;  end
                    default: begin addr_mux = CARRIER_CENTER_FREQUENCY; data_mux = point;      end
                endcase
                if (timeout)      state_nxt = FINISH;
                else if (accept)  state_nxt = WAIT_ACK;
                else if (i_abort) state_nxt = FINISH;
            end
            WAIT_ACK: begin
                pending = 1'b1;
                if (ok) begin
                    if (i_abort)                              state_nxt = FINISH;
                    else if (wr_addr == MODULATION_FREQUENCY) state_nxt = WR_DEV;
                    else if (wr_addr == MODULATION_DEVIATION) state_nxt = WR_CF;
                    else if (last_point)                      state_nxt = FINISH;
                    else if (dwell_r == '0)                   state_nxt = WR_CF;
                    else                                      state_nxt = DWELL;
                end else if (timeout) begin
                    state_nxt = FINISH;
                end
            end
            DWELL: begin
                if (i_abort)                                    state_nxt = FINISH;
                else if (dwell_cnt + DWELL_W'(1) == dwell_r)    state_nxt = WR_CF;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Settings latch, sweep point, sticky error and acknowledged-carrier tracking.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: settings registers reset to the generator's defaults so a stray pre-start read is meaningful.
        if (!i_reset_n) begin
            start_r    <= DW'(DEFAULT_CARRIER);
            stop_r     <= DW'(DEFAULT_CARRIER);
            step_r     <= '0;
            dwell_r    <= '0;
            mod_freq_r <= DW'(DEFAULT_MOD_FREQ);
            mod_dev_r  <= DW'(DEFAULT_MOD_DEV);
            point      <= DW'(DEFAULT_CARRIER);
            wr_addr    <= CARRIER_CENTER_FREQUENCY;
            err_r      <= 1'b0;
            cur_freq_r <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                start_r    <= i_start_freq;
                stop_r     <= i_stop_freq;
                step_r     <= i_step;
                dwell_r    <= i_dwell;
                mod_freq_r <= i_mod_freq;
                mod_dev_r  <= i_mod_dev;
                point      <= i_start_freq;
                err_r      <= 1'b0;
            end
            if (accept) wr_addr <= addr_mux;
            if (timeout) err_r <= 1'b1;
            if (ok && wr_addr == CARRIER_CENTER_FREQUENCY) begin
                cur_freq_r <= point;
                point      <= next_point;
            end
        end
    end

    // Dwell timer runs only while in DWELL.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)          dwell_cnt <= '0;
        else if (state == DWELL) dwell_cnt <= dwell_cnt + DWELL_W'(1);
        else                     dwell_cnt <= '0;
    end

    assign o_busy     = (state != IDLE);
    assign o_done     = (state == FINISH);
    assign o_err      = err_r;
    assign o_cur_freq = cur_freq_r;

    // Read data is never used: this master only writes.
    assign unused_ok = ^{i_wb_data, wr_busy};

endmodule

// File: doc/fm_sweep_wb_master.md
Name: fm_sweep_wb_master

Overview:
- Wishbone pipelined master that drives the FM generator's register slave.
- On a start pulse it programs:
  - modulation frequency (addr 1);
  - modulation deviation (addr 2);
  - carrier centre frequency (addr 0), stepped from a start value to a stop value with a programmable dwell between writes.
- Sits between the control/CPU side and the FM generator, replacing software-timed register pokes for frequency sweeps.

Parameters:
- DW, 32, Wishbone data width and frequency word width.
- DWELL_W, 16, width of dwell counter.
- TIMEOUT, 16, max cycles allowed for stall-hold or ack wait before error.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  pulse; latches all i_* settings and begins a sweep (ignored while busy)
- i_abort  in  1  level/pulse; terminates sweep at next safe point
- i_start_freq  in  DW  first carrier increment written
- i_stop_freq  in  DW  last carrier increment written
- i_step  in  DW  unsigned increment between sweep points
- i_dwell  in  DWELL_W  idle cycles between carrier writes
- i_mod_freq  in  DW  value for addr 1
- i_mod_dev  in  DW  value for addr 2
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  Wishbone controls (we always 1 when stb)
- o_wb_addr  out  2  register address
- o_wb_data  out  DW  write data
- i_wb_ack, i_wb_stall  in  1  slave response
- i_wb_data  in  DW  read data (unused, writes only)
- o_busy  out  1  high from start acceptance until IDLE
- o_done  out  1  one-cycle pulse at sweep end (normal or error)
- o_err  out  1  sticky timeout flag, cleared on next accepted start
- o_cur_freq  out  DW  last carrier value acknowledged

Behaviour:
- Reset (async, i_reset_n low):
  - cyc/stb/we = 0; addr/data = 0.
  - busy/done/err = 0; o_cur_freq = 0.
  - FSM = IDLE.
  - Reset mid-transaction drops cyc immediately.
- States: IDLE, WR_MF, WR_DEV, WR_CF, WAIT_ACK, DWELL, FINISH.
- One outstanding transaction at a time. Each write:
  - issue state asserts cyc=stb=we=1 with addr/data;
  - stb held (addr/data stable) while i_wb_stall=1;
  - on stb & !stall, stb drops next cycle → WAIT_ACK, cyc stays high;
  - on i_wb_ack, cyc drops the next cycle and FSM advances.
- Ack arriving in the same cycle as strobe acceptance is a protocol violation; ignore it.
- Timing with a zero-stall, one-cycle-ack slave, i_start at cycle N:
  - stb(addr1) at N+1, stb(addr2) at N+3, stb(addr0=start) at N+5;
  - ack at N+6; o_cur_freq updated at N+7;
  - DWELL lasts i_dwell cycles; next WR_CF stb at N+7+i_dwell;
  - i_dwell=0 → back-to-back writes, 2 cycles per write.
- Sweep arithmetic, computed in DW+1 bits (no wrap):
  - next = cur + step;
  - if cur == stop, or step == 0, or start > stop → FINISH after the current write;
  - else next value = min(cur+step, stop), so stop is always written exactly once as the final point.
- FINISH:
  - o_done = 1 for one cycle, busy = 0 next cycle, → IDLE.
- Timeout:
  - counter cleared on entering each issue state and on strobe acceptance;
  - if it reaches TIMEOUT while stalled or awaiting ack: drop cyc/stb next cycle, set o_err, → FINISH.
- Abort:
  - in DWELL or an issue state with stb not yet accepted: drop stb/cyc next cycle → FINISH;
  - in WAIT_ACK: wait for ack or timeout first, so no transaction is ever orphaned;
  - o_err is unaffected by abort.
- i_start while busy is ignored. Simultaneous i_start and i_abort in IDLE: start wins; abort is sampled from the next cycle.
- Settings are latched at start; input changes mid-sweep have no effect.

Decomposition:
- Shared package fm_wb_pkg holds:
  - register address constants: CARRIER_CENTER_FREQUENCY=0, MODULATION_FREQUENCY=1, MODULATION_DEVIATION=2;
  - FSM state encoding;
  - reset default values: carrier 32'h444444, mod freq 32'h1bf, deviation 0.
- One sub-module, wb_single_write, encapsulates:
  - the stb/stall/ack handshake and timeout counter;
  - interface: req, addr, data → busy, ok, timeout.

Test Plan:
- Zero-stall 1-cycle-ack slave; start=100, stop=130, step=10, dwell=3, mod_freq=0x1bf, dev=5 → writes addr1=0x1bf, addr2=5, then addr0 = 100, 110, 120, 130 with 3 idle cycles between carrier writes; o_done once; o_err=0; o_cur_freq=130.
- Same settings with stop=125 → carrier writes 100, 110, 120, 125; no value above 125.
- Slave stalls 4 cycles on each write → addr/data held stable throughout the stall; same write sequence; one stb acceptance per write.
- Slave never acks, TIMEOUT=16 → cyc drops within 17 cycles of acceptance; o_err=1, o_done pulse; next start clears o_err.
- Edge cases: step=0, or start=200 > stop=100 → exactly three writes (1, 2, 0 with value start), then done. i_abort during DWELL after the second point → no further writes, done pulse.
- i_reset_n low while awaiting ack → cyc/stb=0 combinationally; all outputs at reset values; a clean restart after reset produces the full sequence.
